// File: rtl/instr_fetch_buffer_if.sv
// Purpose : Bundles the host byte stream, the core instruction handshake and the
//           debug status of the instruction fetch buffer into one interface.
// Signals : byte_in/byte_valid/byte_ready  host -> buffer byte handshake
//           flush                          discard queued and partial words
//           instr_out/instr_valid/instr_ready  buffer -> core word handshake
//           count, fetch_pc, half_word     status for debug
// Modports: master = host/core side driving the inputs, slave = the buffer.
interface instr_fetch_buffer_if #(
  parameter int ADDR_W = 2
);
  logic [7:0]      byte_in;
  logic            byte_valid;
  logic            byte_ready;
  logic            flush;
  logic [15:0]     instr_out;
  logic            instr_valid;
  logic            instr_ready;
  logic [ADDR_W:0] count;
  logic [7:0]      fetch_pc;
  logic            half_word;

  modport master (
    output byte_in, byte_valid, flush, instr_ready,
    input  byte_ready, instr_out, instr_valid, count, fetch_pc, half_word
  );

  modport slave (
    input  byte_in, byte_valid, flush, instr_ready,
    output byte_ready, instr_out, instr_valid, count, fetch_pc, half_word
  );
endinterface

// File: rtl/instr_fetch_buffer.sv
// Purpose : Fetch stage for the mini RISC core. Assembles host bytes (low byte
//           first) into 16-bit instruction words, queues them in a DEPTH-entry
//           FIFO and hands them to the core over valid/ready. fetch_pc counts
//           delivered words modulo 256.
// Ports   : clk  - clock, rising edge
//           rst  - synchronous active-high reset
//           bus  - instr_fetch_buffer_if.slave (byte and instruction handshakes,
//                  flush, count, fetch_pc, half_word)
module instr_fetch_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  instr_fetch_buffer_if.slave        bus
);

  typedef enum logic {LOW = 1'b0, HIGH = 1'b1} asm_state_t;

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  asm_state_t        state_q, state_d;
  logic [7:0]        lo_q;
  logic [15:0]       mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [7:0]        fetch_pc_q, fetch_pc_d;

  logic full, empty, accept, pop, push;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  // byte_ready depends only on registered state so the core's instr_ready
  // never reaches the host side combinationally.
  assign bus.byte_ready  = (state_q == LOW) | ~full;
  assign bus.instr_valid = ~empty;
  assign bus.instr_out   = mem_q[rd_ptr_q];
  assign bus.count       = count_q;
  assign bus.fetch_pc    = fetch_pc_q;
  assign bus.half_word   = (state_q == HIGH);

  // A flush cancels whatever accept/pop would have happened in that cycle.
  assign accept = bus.byte_valid & bus.byte_ready & ~bus.flush;
  assign pop    = bus.instr_valid & bus.instr_ready & ~bus.flush;
  assign push   = accept & (state_q == HIGH);

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    fetch_pc_d = fetch_pc_q;

    if (bus.flush) begin
      state_d  = LOW;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (accept) begin
        state_d = (state_q == LOW) ? HIGH : LOW;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d   = rd_ptr_q + 1'b1;
        fetch_pc_d = fetch_pc_q + 8'd1;
      end
      // Simultaneous push and pop leaves the occupancy unchanged.
      if (push && !pop) begin
        count_d = count_q + 1'b1;
      end else if (pop && !push) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LOW;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      fetch_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  // Data storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (!rst && accept && state_q == LOW) begin
      lo_q <= bus.byte_in;
    end
    if (!rst && push) begin
      mem_q[wr_ptr_q] <= {bus.byte_in, lo_q};
    end
  end

endmodule

// File: tb/tb_instr_fetch_buffer.sv
module tb_instr_fetch_buffer;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  instr_fetch_buffer_if #(.ADDR_W(2)) bus ();

  instr_fetch_buffer #(.DEPTH(4), .ADDR_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.byte_in     = 8'h00;
    bus.byte_valid  = 1'b0;
    bus.flush       = 1'b0;
    bus.instr_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    cyc();
    bus.byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w);
    send_byte(w[7:0]);
    send_byte(w[15:8]);
  endtask

  task automatic pop_one();
    bus.instr_ready = 1'b1;
    cyc();
    bus.instr_ready = 1'b0;
  endtask

  task automatic test_reset();
    // Dirty the state first so reset has something to clear.
    do_reset();
    send_word(16'hBEEF);
    pop_one();
    send_byte(8'h11);
    do_reset();
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", bus.instr_valid); end
    checks++; if (bus.half_word !== 1'b0) begin errors++; $display("FAIL reset_half got %0b want 0", bus.half_word); end
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.count); end
    checks++; if (bus.fetch_pc !== 8'd0) begin errors++; $display("FAIL reset_pc got %0d want 0", bus.fetch_pc); end
    checks++; if (bus.byte_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", bus.byte_ready); end
  endtask

  task automatic test_assemble();
    do_reset();
    send_byte(8'h85);
    checks++; if (bus.half_word !== 1'b1) begin errors++; $display("FAIL asm_half got %0b want 1", bus.half_word); end
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL asm_early_valid got %0b want 0", bus.instr_valid); end
    send_byte(8'h12);
    checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL asm_valid got %0b want 1", bus.instr_valid); end
    checks++; if (bus.instr_out !== 16'h1285) begin errors++; $display("FAIL asm_word got %h want 1285", bus.instr_out); end
    checks++; if (bus.count !== 3'd1) begin errors++; $display("FAIL asm_count got %0d want 1", bus.count); end
    checks++; if (bus.half_word !== 1'b0) begin errors++; $display("FAIL asm_half_low got %0b want 0", bus.half_word); end
    pop_one();
    checks++; if (bus.count !== 3'd0 || bus.fetch_pc !== 8'd1) begin errors++; $display("FAIL asm_pop count=%0d pc=%0d want 0 1", bus.count, bus.fetch_pc); end
  endtask

  task automatic test_backpressure();
    logic [15:0] exp [5];
    exp[0] = 16'h1001; exp[1] = 16'h2002; exp[2] = 16'h3003; exp[3] = 16'h4004; exp[4] = 16'h6655;
    do_reset();
    for (int i = 0; i < 4; i++) send_word(exp[i]);
    checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL bp_full_count got %0d want 4", bus.count); end
    checks++; if (bus.byte_ready !== 1'b1) begin errors++; $display("FAIL bp_low_ready got %0b want 1", bus.byte_ready); end
    send_byte(8'h55);
    checks++; if (bus.half_word !== 1'b1) begin errors++; $display("FAIL bp_half got %0b want 1", bus.half_word); end
    checks++; if (bus.byte_ready !== 1'b0) begin errors++; $display("FAIL bp_ready got %0b want 0", bus.byte_ready); end
    // Host holds the high byte while stalled.
    bus.byte_in = 8'h66; bus.byte_valid = 1'b1;
    cyc(); cyc();
    checks++; if (bus.byte_ready !== 1'b0 || bus.count !== 3'd4 || bus.half_word !== 1'b1) begin errors++; $display("FAIL bp_stall ready=%0b count=%0d half=%0b want 0 4 1", bus.byte_ready, bus.count, bus.half_word); end
    checks++; if (bus.instr_out !== exp[0]) begin errors++; $display("FAIL bp_head0 got %h want %h", bus.instr_out, exp[0]); end
    bus.instr_ready = 1'b1;
    cyc();
    bus.instr_ready = 1'b0;
    checks++; if (bus.count !== 3'd3 || bus.byte_ready !== 1'b1) begin errors++; $display("FAIL bp_after_pop count=%0d ready=%0b want 3 1", bus.count, bus.byte_ready); end
    cyc();
    bus.byte_valid = 1'b0;
    checks++; if (bus.count !== 3'd4 || bus.half_word !== 1'b0) begin errors++; $display("FAIL bp_refill count=%0d half=%0b want 4 0", bus.count, bus.half_word); end
    for (int i = 1; i < 5; i++) begin
      checks++; if (bus.instr_out !== exp[i]) begin errors++; $display("FAIL bp_order%0d got %h want %h", i, bus.instr_out, exp[i]); end
      pop_one();
      if (i == 3) begin
        checks++; if (bus.fetch_pc !== 8'd4) begin errors++; $display("FAIL bp_pc4 got %0d want 4", bus.fetch_pc); end
      end
    end
    checks++; if (bus.instr_valid !== 1'b0 || bus.fetch_pc !== 8'd5) begin errors++; $display("FAIL bp_drained valid=%0b pc=%0d want 0 5", bus.instr_valid, bus.fetch_pc); end
  endtask

  task automatic test_push_pop_same();
    do_reset();
    send_word(16'h1111);
    send_word(16'h2222);
    send_byte(8'h33);
    bus.byte_in = 8'h44; bus.byte_valid = 1'b1; bus.instr_ready = 1'b1;
    cyc();
    idle_inputs();
    checks++; if (bus.count !== 3'd2) begin errors++; $display("FAIL pp_count got %0d want 2", bus.count); end
    checks++; if (bus.instr_out !== 16'h2222) begin errors++; $display("FAIL pp_head got %h want 2222", bus.instr_out); end
    pop_one();
    checks++; if (bus.instr_out !== 16'h4433) begin errors++; $display("FAIL pp_next got %h want 4433", bus.instr_out); end
    pop_one();
    checks++; if (bus.count !== 3'd0 || bus.fetch_pc !== 8'd3) begin errors++; $display("FAIL pp_end count=%0d pc=%0d want 0 3", bus.count, bus.fetch_pc); end
  endtask

  task automatic test_flush();
    do_reset();
    send_word(16'h7777);
    send_byte(8'hA1);
    checks++; if (bus.half_word !== 1'b1 || bus.count !== 3'd1) begin errors++; $display("FAIL fl_pre half=%0b count=%0d want 1 1", bus.half_word, bus.count); end
    bus.flush = 1'b1; bus.byte_in = 8'hFF; bus.byte_valid = 1'b1; bus.instr_ready = 1'b1;
    cyc();
    idle_inputs();
    checks++; if (bus.count !== 3'd0 || bus.half_word !== 1'b0 || bus.instr_valid !== 1'b0) begin errors++; $display("FAIL fl_clear count=%0d half=%0b valid=%0b want 0 0 0", bus.count, bus.half_word, bus.instr_valid); end
    checks++; if (bus.fetch_pc !== 8'd0) begin errors++; $display("FAIL fl_pc got %0d want 0", bus.fetch_pc); end
    send_byte(8'h83);
    send_byte(8'h04);
    checks++; if (bus.instr_out !== 16'h0483 || bus.count !== 3'd1) begin errors++; $display("FAIL fl_after got %h count=%0d want 0483 1", bus.instr_out, bus.count); end
  endtask

  task automatic test_wrap_and_midword_reset();
    logic [15:0] w;
    int bad;
    do_reset();
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      w = {~8'(i), 8'(i)};
      send_word(w);
      if (bus.instr_out !== w) begin
        bad++;
        if (bad < 4) $display("FAIL wrap_word%0d got %h want %h", i, bus.instr_out, w);
      end
      pop_one();
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL wrap_data bad_words=%0d want 0", bad); end
    checks++; if (bus.fetch_pc !== 8'd0 || bus.count !== 3'd0) begin errors++; $display("FAIL wrap_pc pc=%0d count=%0d want 0 0", bus.fetch_pc, bus.count); end
    send_word(16'hCAFE);
    send_byte(8'h12);
    checks++; if (bus.fetch_pc !== 8'd0 || bus.instr_out !== 16'hCAFE) begin errors++; $display("FAIL wrap_next pc=%0d out=%h want 0 cafe", bus.fetch_pc, bus.instr_out); end
    pop_one();
    checks++; if (bus.fetch_pc !== 8'd1 || bus.half_word !== 1'b1) begin errors++; $display("FAIL mid_pre pc=%0d half=%0b want 1 1", bus.fetch_pc, bus.half_word); end
    send_word(16'h5A5A);
    send_byte(8'h34);
    do_reset();
    checks++; if (bus.instr_valid !== 1'b0 || bus.half_word !== 1'b0 || bus.count !== 3'd0 || bus.fetch_pc !== 8'd0 || bus.byte_ready !== 1'b1) begin
      errors++; $display("FAIL mid_reset valid=%0b half=%0b count=%0d pc=%0d ready=%0b want 0 0 0 0 1", bus.instr_valid, bus.half_word, bus.count, bus.fetch_pc, bus.byte_ready);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_assemble();
    test_backpressure();
    test_push_pop_same();
    test_flush();
    test_wrap_and_midword_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
